inner_affine_sched_gen: RTL and testbench

Schedule-side partner to the inner affine address controller. It tracks a 6-deep affine loop nest in time: a free-running cycle counter is compared against an affine schedule expression, and a one-cycle `valid_output` is raised exactly when the next iteration is due. `valid_output` is wired to the address controller's `step` input, so the two walk the same iteration space in lockstep.

---
 rtl/inner_affine_sched_gen.sv | 143 ++++++++++++++
 tb/tb_inner_affine_sched_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/inner_affine_sched_gen.sv
// ---------------------------------------------------------------------------
// inner_affine_sched_gen
//
// Schedule-side partner to the inner affine address controller. A free-running
// cycle counter is compared with an affine schedule expression built from a
// 6-deep loop nest. A one-cycle valid_output is raised when the next iteration
// is due. valid_output drives the address controller's step input, so both
// blocks walk the same iteration space in lockstep.
//
// Ports:
//   clk             clock
//   rst             synchronous active-high reset
//   clk_en          global clock enable; all state holds while low
//   flush           synchronous schedule restart, qualified by clk_en
//   dimensionality  active loop count (values above 6 act as 6)
//   ranges          trip count per dimension, dim 0 innermost (0 acts as 1)
//   strides         schedule delay added per iteration of each dimension
//   starting_cycle  cycle offset of the first iteration
//   valid_output    iteration due this cycle (combinational)
//   cycle_count     current cycle counter
//   sched_out       scheduled cycle of the next pending iteration
//   done            sticky; all iterations issued
//   miss            sticky schedule-miss flag
//
// Optional feature macro: INNER_AFFINE_SCHED_MISS_DETECT_EN
//   When defined, miss sets if the counter has passed the pending schedule
//   point without an event. When undefined, miss is tied low and no compare
//   logic is built.
// ---------------------------------------------------------------------------
module inner_affine_sched_gen (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             flush,
    input  logic [3:0]       dimensionality,
    input  logic [5:0][15:0] ranges,
    input  logic [5:0][15:0] strides,
    input  logic [15:0]      starting_cycle,
    output logic             valid_output,
    output logic [15:0]      cycle_count,
    output logic [15:0]      sched_out,
    output logic             done,
    output logic             miss
);

    logic [15:0] dim_counter [6];
    logic [15:0] current_loc [6];

    logic [2:0]  act_dims;
    logic [5:0]  active;
    logic [5:0]  at_last;
    logic [6:0]  upd;
    logic        all_done;
    logic [15:0] range_m1 [6];
    logic [15:0] sched_acc;

    // Clamp the loop count, derive per-dimension wrap points and build the
    // schedule sum plus the carry-style update chain from the innermost loop.
    // A range of 0 behaves like 1, so its wrap point is 0 rather than 0xFFFF.
    always_comb begin
        act_dims  = (dimensionality > 4'd6) ? 3'd6 : dimensionality[2:0];
        sched_acc = starting_cycle;
        upd       = '0;
        upd[0]    = 1'b1;
        active    = '0;
        at_last   = '0;
        for (int i = 0; i < 6; i++) begin
            range_m1[i] = (ranges[i] == 16'd0) ? 16'd0 : ranges[i] - 16'd1;
            active[i]   = (3'(i) < act_dims);
            at_last[i]  = (dim_counter[i] == range_m1[i]);
            upd[i+1]    = upd[i] & at_last[i];
            if (active[i]) begin
                sched_acc = sched_acc + current_loc[i];
            end
        end
        // With zero active loops upd[0] is 1, so the single event finishes.
        all_done = upd[act_dims];
    end

    assign sched_out    = sched_acc;
    assign valid_output = clk_en & ~flush & ~rst & ~done & (cycle_count == sched_out);

    // Loop-nest state. Reset beats flush, flush beats the normal advance, and
    // clk_en low freezes everything apart from reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= 16'd0;
            done        <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                dim_counter[i] <= 16'd0;
                current_loc[i] <= 16'd0;
            end
        end else if (clk_en) begin
            if (flush) begin
                cycle_count <= 16'd0;
                done        <= 1'b0;
                for (int i = 0; i < 6; i++) begin
                    dim_counter[i] <= 16'd0;
                    current_loc[i] <= 16'd0;
                end
            end else begin
                cycle_count <= cycle_count + 16'd1;
                if (valid_output) begin
                    for (int i = 0; i < 6; i++) begin
                        if (active[i] && upd[i]) begin
                            if (at_last[i]) begin
                                dim_counter[i] <= 16'd0;
                                current_loc[i] <= 16'd0;
                            end else begin
                                dim_counter[i] <= dim_counter[i] + 16'd1;
                                current_loc[i] <= current_loc[i] + strides[i];
                            end
                        end
                    end
                    if (all_done) begin
                        done <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef INNER_AFFINE_SCHED_MISS_DETECT_EN
    logic miss_hit;

    // The counter has overtaken the pending iteration without issuing it, so
    // the schedule has fallen behind (nonmonotonic/overlapping or wrapped).
    assign miss_hit = clk_en & ~flush & ~done & ~valid_output & (cycle_count > sched_out);

    always_ff @(posedge clk) begin
        if (rst) begin
            miss <= 1'b0;
        end else if (clk_en && flush) begin
            miss <= 1'b0;
        end else if (miss_hit) begin
            miss <= 1'b1;
        end
    end
`else
    assign miss = 1'b0;
`endif

endmodule

// File: tb/tb_inner_affine_sched_gen.sv
// ---------------------------------------------------------------------------
// tb_inner_affine_sched_gen
//
// Directed bench for inner_affine_sched_gen. Each scenario pushes the events
// it expects (cycle_count, sched_out and wall-clock cycle since reset release)
// into a queue; a monitor pops one entry per valid_output and compares.
// ---------------------------------------------------------------------------
module tb_inner_affine_sched_gen;

    logic             clk;
    logic             rst;
    logic             clk_en;
    logic             flush;
    logic [3:0]       dimensionality;
    logic [5:0][15:0] ranges;
    logic [5:0][15:0] strides;
    logic [15:0]      starting_cycle;
    logic             valid_output;
    logic [15:0]      cycle_count;
    logic [15:0]      sched_out;
    logic             done;
    logic             miss;

    typedef struct {
        logic [15:0] cc;
        logic [15:0] sched;
        int          wall;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;
    int   wall;

`ifdef INNER_AFFINE_SCHED_MISS_DETECT_EN
    localparam logic MISS_EXP = 1'b1;
`else
    localparam logic MISS_EXP = 1'b0;
`endif

    inner_affine_sched_gen dut (
        .clk            (clk),
        .rst            (rst),
        .clk_en         (clk_en),
        .flush          (flush),
        .dimensionality (dimensionality),
        .ranges         (ranges),
        .strides        (strides),
        .starting_cycle (starting_cycle),
        .valid_output   (valid_output),
        .cycle_count    (cycle_count),
        .sched_out      (sched_out),
        .done           (done),
        .miss           (miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wall-clock cycles since reset release, independent of clk_en and flush.
    always @(posedge clk) begin
        if (rst) wall <= 0;
        else     wall <= wall + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: every event seen on valid_output must match the queue head.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (valid_output === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_valid: got event at cycle_count %0d, expected none (t=%0t)",
                         cycle_count, $time);
            end else begin
                e = exp_q.pop_front();
                checkOutput("event_cycle_count", {16'd0, cycle_count}, {16'd0, e.cc});
                checkOutput("event_sched_out", {16'd0, sched_out}, {16'd0, e.sched});
                checkOutput("event_wall_cycle", wall, e.wall);
            end
        end
    end

    task automatic pushEvent(input logic [15:0] c, input int w);
        exp_t e;
        e.cc    = c;
        e.sched = c;
        e.wall  = w;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Program a configuration and reset the DUT, checking reset values.
    // Inactive dimensions get non-trivial ranges/strides so leakage shows up.
    task automatic applyStimulus(input logic [3:0] dim, input logic [15:0] r0, input logic [15:0] r1,
                                 input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] start);
        dimensionality = dim;
        ranges         = {16'd5, 16'd5, 16'd5, 16'd5, r1, r0};
        strides        = {16'd7, 16'd7, 16'd7, 16'd7, s1, s0};
        starting_cycle = start;
        clk_en         = 1'b1;
        flush          = 1'b0;
        rst            = 1'b1;
        tick();
        tick();
        checkOutput("reset_cycle_count", {16'd0, cycle_count}, 32'd0);
        checkOutput("reset_valid", {31'd0, valid_output}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_miss", {31'd0, miss}, 32'd0);
        checkOutput("reset_sched_out", {16'd0, sched_out}, {16'd0, start});
        rst = 1'b0;
    endtask

    task automatic waitCount(input logic [15:0] target, input int budget);
        int n = 0;
        while (cycle_count !== target && n < budget) begin
            tick();
            n++;
        end
        checkOutput("wait_cycle_count", {16'd0, cycle_count}, {16'd0, target});
    endtask

    task automatic waitDone(input int budget, input logic [15:0] cc_at_done, input int wall_at_done);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checkOutput("done_set", {31'd0, done}, 32'd1);
        checkOutput("done_cycle_count", {16'd0, cycle_count}, {16'd0, cc_at_done});
        checkOutput("done_wall_cycle", wall, wall_at_done);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst            = 1'b1;
        clk_en         = 1'b1;
        flush          = 1'b0;
        dimensionality = 4'd0;
        ranges         = '0;
        strides        = '0;
        starting_cycle = 16'd0;

        // Single loop: range 4, stride 2, start 3.
        applyStimulus(4'd1, 16'd4, 16'd0, 16'd2, 16'd0, 16'd3);
        pushEvent(16'd3, 3); pushEvent(16'd5, 5); pushEvent(16'd7, 7); pushEvent(16'd9, 9);
        waitDone(40, 16'd10, 10);
        repeat (8) tick();
        checkOutput("done_sticky", {31'd0, done}, 32'd1);
        checkOutput("sched_after_done", {16'd0, sched_out}, 32'd3);
        checkOutput("queue_empty_t1", exp_q.size(), 32'd0);

        // Two loops: ranges {2,3}, strides {1,4}, start 0.
        applyStimulus(4'd2, 16'd2, 16'd3, 16'd1, 16'd4, 16'd0);
        pushEvent(16'd0, 0); pushEvent(16'd1, 1); pushEvent(16'd4, 4);
        pushEvent(16'd5, 5); pushEvent(16'd8, 8); pushEvent(16'd9, 9);
        waitDone(40, 16'd10, 10);
        checkOutput("miss_clean_t2", {31'd0, miss}, 32'd0);
        checkOutput("queue_empty_t2", exp_q.size(), 32'd0);

        // clk_en low for two cycles at cycle_count 4: events slip two wall cycles.
        applyStimulus(4'd1, 16'd4, 16'd0, 16'd2, 16'd0, 16'd3);
        pushEvent(16'd3, 3); pushEvent(16'd5, 7); pushEvent(16'd7, 9); pushEvent(16'd9, 11);
        waitCount(16'd4, 20);
        clk_en = 1'b0;
        tick();
        tick();
        checkOutput("hold_cycle_count", {16'd0, cycle_count}, 32'd4);
        clk_en = 1'b1;
        waitDone(40, 16'd10, 12);
        checkOutput("queue_empty_t3", exp_q.size(), 32'd0);

        // Flush at cycle_count 6 after events 3 and 5: schedule replays.
        applyStimulus(4'd1, 16'd4, 16'd0, 16'd2, 16'd0, 16'd3);
        pushEvent(16'd3, 3); pushEvent(16'd5, 5);
        pushEvent(16'd3, 10); pushEvent(16'd5, 12); pushEvent(16'd7, 14); pushEvent(16'd9, 16);
        waitCount(16'd6, 20);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_cycle_count", {16'd0, cycle_count}, 32'd0);
        checkOutput("flush_done", {31'd0, done}, 32'd0);
        checkOutput("flush_sched_out", {16'd0, sched_out}, 32'd3);
        waitDone(40, 16'd10, 17);
        checkOutput("queue_empty_t4", exp_q.size(), 32'd0);

        // Zero dimensions, start 5: one event then done.
        applyStimulus(4'd0, 16'd4, 16'd3, 16'd2, 16'd1, 16'd5);
        pushEvent(16'd5, 5);
        waitDone(20, 16'd6, 6);
        repeat (4) tick();
        checkOutput("queue_empty_t5", exp_q.size(), 32'd0);

        // Zero dimensions, start 0: no event during reset, first one right after.
        applyStimulus(4'd0, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0);
        pushEvent(16'd0, 0);
        waitDone(10, 16'd1, 1);
        repeat (4) tick();
        checkOutput("queue_empty_t6", exp_q.size(), 32'd0);

        // Stride 0: second iteration is due at a cycle already passed.
        applyStimulus(4'd1, 16'd3, 16'd0, 16'd0, 16'd0, 16'd2);
        pushEvent(16'd2, 2);
        waitCount(16'd6, 20);
        checkOutput("stall_sched_out", {16'd0, sched_out}, 32'd2);
        checkOutput("stall_done", {31'd0, done}, 32'd0);
        checkOutput("stall_miss", {31'd0, miss}, {31'd0, MISS_EXP});
        repeat (4) tick();
        checkOutput("stall_miss_sticky", {31'd0, miss}, {31'd0, MISS_EXP});
        checkOutput("queue_empty_t7", exp_q.size(), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_clears_miss", {31'd0, miss}, 32'd0);
        checkOutput("flush_cycle_count_t7", {16'd0, cycle_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
